// File: rtl/dac_stream_buffer.sv
// dac_stream_buffer
//   Dual-channel sample buffer in front of the DAC output stage. Packed A/B
//   sample pairs arrive on an AXI4-Stream slave, are queued in a circular
//   FIFO and, once the FIFO has primed to START_LEVEL, released one pair per
//   dac_clk. An empty FIFO while playing is an underrun: outputs hold, a
//   sticky flag and a saturating counter record it, and playback re-primes.
//
//   Optional feature macro: DAC_STREAM_OFFSET_EN
//     defined   -> ports offset_a/offset_b exist; each popped sample becomes
//                  sat14(sample + offset), offsets sampled on the pop edge.
//     undefined -> samples pass through unchanged.
//
// Ports
//   dac_clk, dac_rstn        clock, async active-low reset
//   enable                   playback enable; low flushes FIFO and idles
//   s_axis_tdata[31:0]       [13:0] ch A, [29:16] ch B (signed, 14 bit)
//   s_axis_tvalid/tready     AXI4-Stream handshake
//   offset_a/offset_b[13:0]  signed per-channel offsets (macro only)
//   dac_dat_a_o/b_o[13:0]    registered signed samples to the DAC stage
//   running                  high while playing
//   fill_level               current FIFO occupancy
//   underrun                 sticky underrun flag (cleared by enable low)
//   underrun_count[15:0]     saturating underrun counter

// Per-channel output path: signed add of the offset with clamp to 14 bits.
// With a zero offset this is a pass-through.
module dac_stream_lane #(
    parameter int SAMPLE_W = 14
) (
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] offset,
    output logic [SAMPLE_W-1:0] result
);
    logic [SAMPLE_W:0] sum;

    always_comb begin
        sum = {sample[SAMPLE_W-1], sample} + {offset[SAMPLE_W-1], offset};
        // top two bits disagree -> the sum left the 14-bit range
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
            result = sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_W-1){1'b1}}};
        else
            result = sum[SAMPLE_W-1:0];
    end
endmodule

module dac_stream_buffer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 8
) (
    input  logic                          dac_clk,
    input  logic                          dac_rstn,
    input  logic                          enable,
    input  logic [31:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
`ifdef DAC_STREAM_OFFSET_EN
    input  logic [13:0]                   offset_a,
    input  logic [13:0]                   offset_b,
`endif
    output logic [13:0]                   dac_dat_a_o,
    output logic [13:0]                   dac_dat_b_o,
    output logic                          running,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          underrun,
    output logic [15:0]                   underrun_count
);
    localparam int NUM_LANES = 2;   // lane 0 = ch A, lane 1 = ch B
    localparam int SAMPLE_W  = 14;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] START_LVL = (AW+1)'(START_LEVEL);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    state_t state, state_nxt;

    logic [NUM_LANES-1:0][SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [NUM_LANES-1:0][SAMPLE_W-1:0] in_pair, head_pair, offs, out_pair, dat_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en, underrun_evt;
    logic          unused_tdata;

    assign in_pair      = {s_axis_tdata[29:16], s_axis_tdata[13:0]};
    assign unused_tdata = ^{s_axis_tdata[31:30], s_axis_tdata[15:14]};
    assign head_pair    = mem[rd_ptr];

`ifdef DAC_STREAM_OFFSET_EN
    assign offs = {offset_b, offset_a};
`else
    assign offs = '0;
`endif

    // Ready is purely a function of registered state and occupancy.
    assign s_axis_tready = (state != S_IDLE) && (fill_level < FULL_LVL);
    // A write in a flush cycle would be wiped anyway; gating keeps the
    // pointer/level update unambiguous.
    assign wr_en = s_axis_tvalid && s_axis_tready && enable;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dac_stream_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
            .sample (head_pair[l]),
            .offset (offs[l]),
            .result (out_pair[l])
        );
    end

    always_comb begin
        state_nxt    = state;
        rd_en        = 1'b0;
        underrun_evt = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_PRIME;
                S_PRIME: if (fill_level >= START_LVL) state_nxt = S_RUN;
                S_RUN: begin
                    if (fill_level != '0) begin
                        rd_en = 1'b1;
                    end else begin
                        underrun_evt = 1'b1;
                        state_nxt    = S_PRIME;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            state          <= S_IDLE;
            running        <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_level     <= '0;
            dat_q          <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == S_RUN);
            if (!enable) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fill_level     <= '0;
                dat_q          <= '0;
                underrun       <= 1'b0;
                underrun_count <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    dat_q  <= out_pair;
                end
                case ({wr_en, rd_en})
                    2'b10:   fill_level <= fill_level + 1'b1;
                    2'b01:   fill_level <= fill_level - 1'b1;
                    default: ;
                endcase
                if (underrun_evt) begin
                    underrun <= 1'b1;
                    if (underrun_count != 16'hFFFF)
                        underrun_count <= underrun_count + 16'd1;
                end
            end
        end
    end

    // Storage needs no reset: only entries below fill_level are ever read.
    always_ff @(posedge dac_clk) begin
        if (wr_en) mem[wr_ptr] <= in_pair;
    end

    assign dac_dat_a_o = dat_q[0];
    assign dac_dat_b_o = dat_q[1];
endmodule

// File: tb/tb_dac_stream_buffer.sv
module tb_dac_stream_buffer;
    localparam int DEPTH = 16;

    logic        dac_clk = 1'b0;
    logic        dac_rstn, enable, enable_f, s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic [13:0] offset_a, offset_b;

    logic        rdy0, run0, und0, rdy1, run1, und1;
    logic [13:0] a0, b0, a1, b1;
    logic [4:0]  fill0, fill1;
    logic [15:0] uc0, uc1;

    int checks = 0;
    int errors = 0;

    always #5 dac_clk = ~dac_clk;

    // primary instance: START_LEVEL 8
    dac_stream_buffer #(.FIFO_DEPTH(DEPTH), .START_LEVEL(8)) dut (
        .dac_clk(dac_clk), .dac_rstn(dac_rstn), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(rdy0),
`ifdef DAC_STREAM_OFFSET_EN
        .offset_a(offset_a), .offset_b(offset_b),
`endif
        .dac_dat_a_o(a0), .dac_dat_b_o(b0), .running(run0),
        .fill_level(fill0), .underrun(und0), .underrun_count(uc0)
    );

    // back-pressure instance: START_LEVEL equals depth
    dac_stream_buffer #(.FIFO_DEPTH(DEPTH), .START_LEVEL(DEPTH)) dut_full (
        .dac_clk(dac_clk), .dac_rstn(dac_rstn), .enable(enable_f),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(rdy1),
`ifdef DAC_STREAM_OFFSET_EN
        .offset_a(offset_a), .offset_b(offset_b),
`endif
        .dac_dat_a_o(a1), .dac_dat_b_o(b1), .running(run1),
        .fill_level(fill1), .underrun(und1), .underrun_count(uc1)
    );

    // ---------------- reference model (queue per instance) ----------------
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          mode_m[2];   // 0 idle, 1 priming, 2 playing
    logic [13:0] oa_m[2], ob_m[2];
    logic        und_m[2];
    int          uc_m[2];

    function automatic logic [13:0] sat14(logic [13:0] x, logic [13:0] o);
        int s;
        s = int'($signed(x)) + int'($signed(o));
        if (s > 8191)  s = 8191;
        if (s < -8192) s = -8192;
        return s[13:0];
    endfunction

    function automatic logic [31:0] pack(int a, int b);
        logic [31:0] d;
        d = $urandom();              // ignored bits get noise
        d[13:0]  = a[13:0];
        d[29:16] = b[13:0];
        return d;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            mode_m[i] = 0; oa_m[i] = '0; ob_m[i] = '0; und_m[i] = 1'b0; uc_m[i] = 0;
        end
    endtask

    task automatic model_step(int i, logic en, logic tv, logic [31:0] d);
        logic [31:0] q[$];
        logic [31:0] h;
        logic        wr;
        int          start;
        if (i == 0) begin q = q0; start = 8; end
        else        begin q = q1; start = DEPTH; end
        if (!en) begin
            q.delete();
            mode_m[i] = 0; oa_m[i] = '0; ob_m[i] = '0; und_m[i] = 1'b0; uc_m[i] = 0;
        end else begin
            wr = tv && (mode_m[i] != 0) && (q.size() < DEPTH);
            if (mode_m[i] == 0) begin
                mode_m[i] = 1;
            end else if (mode_m[i] == 1) begin
                if (q.size() >= start) mode_m[i] = 2;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                oa_m[i] = sat14(h[13:0], offset_a);
                ob_m[i] = sat14(h[29:16], offset_b);
            end else begin
                und_m[i] = 1'b1;
                if (uc_m[i] < 65535) uc_m[i]++;
                mode_m[i] = 1;
            end
            if (wr) q.push_back(d);
        end
        if (i == 0) q0 = q; else q1 = q;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("d0 tready",  32'(rdy0),  32'((mode_m[0] != 0) && (q0.size() < DEPTH)));
        chk("d0 dat_a",   32'(a0),    32'(oa_m[0]));
        chk("d0 dat_b",   32'(b0),    32'(ob_m[0]));
        chk("d0 running", 32'(run0),  32'(mode_m[0] == 2));
        chk("d0 fill",    32'(fill0), 32'(q0.size()));
        chk("d0 underrun",32'(und0),  32'(und_m[0]));
        chk("d0 ucount",  32'(uc0),   32'(uc_m[0]));
        chk("d1 tready",  32'(rdy1),  32'((mode_m[1] != 0) && (q1.size() < DEPTH)));
        chk("d1 dat_a",   32'(a1),    32'(oa_m[1]));
        chk("d1 dat_b",   32'(b1),    32'(ob_m[1]));
        chk("d1 running", 32'(run1),  32'(mode_m[1] == 2));
        chk("d1 fill",    32'(fill1), 32'(q1.size()));
        chk("d1 underrun",32'(und1),  32'(und_m[1]));
        chk("d1 ucount",  32'(uc1),   32'(uc_m[1]));
    endtask

    // inputs are stable here (set #1 after the previous edge)
    task automatic cycle();
        model_step(0, enable, s_axis_tvalid, s_axis_tdata);
        model_step(1, enable_f, s_axis_tvalid, s_axis_tdata);
        @(posedge dac_clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [13:0] ev;
        int          prob;
        int          neg;

        dac_rstn = 1'b0; enable = 1'b0; enable_f = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        offset_a = '0; offset_b = '0;
        model_reset();

        // ---- reset state ----
        #12;
        compare_all();
        chk("rst tready", 32'(rdy0), 32'd0);
        #10;
        dac_rstn = 1'b1;
        cycle();
        cycle();

        // ---- prime and playout, START_LEVEL 8 ----
        enable = 1'b1;
        cycle();                                  // IDLE -> PRIME
        for (int i = 1; i <= 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pack(i, -i);
            cycle();
        end
        s_axis_tvalid = 1'b0;
        chk("prime fill8", 32'(fill0), 32'd8);
        chk("prime not run", 32'(run0), 32'd0);
        cycle();
        chk("prime run", 32'(run0), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cycle();
            neg = -i;
            ev  = neg[13:0];
            chk("play a", 32'(a0), 32'(i));
            chk("play b", 32'(b0), 32'(ev));
        end

        // ---- underrun: last pair holds, flag/count, back to prime ----
        cycle();
        chk("ur hold a", 32'(a0), 32'd8);
        chk("ur flag", 32'(und0), 32'd1);
        chk("ur count", 32'(uc0), 32'd1);
        chk("ur prime", 32'(run0), 32'd0);

        // ---- refill 8 -> RUN resumes; keep streaming ----
        for (int i = 1; i <= 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pack(20 + i, 40 + i);
            cycle();
        end
        s_axis_tdata = pack(99, 98);
        cycle();
        chk("refill run", 32'(run0), 32'd1);
        for (int i = 0; i < 6; i++) begin
            s_axis_tdata = pack(100 + i, -100 - i);
            cycle();
        end

        // ---- flush the primary while streaming ----
        enable = 1'b0;
        cycle();
        chk("flush fill", 32'(fill0), 32'd0);
        chk("flush a", 32'(a0), 32'd0);
        chk("flush ur", 32'(und0), 32'd0);
        chk("flush cnt", 32'(uc0), 32'd0);

        // ---- flush of the second instance at fill 10 ----
        enable_f = 1'b1;
        s_axis_tvalid = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = $urandom();
            cycle();
        end
        chk("f fill10", 32'(fill1), 32'd10);
        enable_f = 1'b0;
        cycle();
        chk("f flush fill", 32'(fill1), 32'd0);
        chk("f flush rdy", 32'(rdy1), 32'd0);

        // ---- full back-pressure, START_LEVEL = DEPTH, tvalid held ----
        enable_f = 1'b1;
        s_axis_tvalid = 1'b0;
        cycle();
        s_axis_tvalid = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            s_axis_tdata = $urandom();
            cycle();
            if (n == 16) begin
                chk("bp full", 32'(fill1), 32'd16);
                chk("bp tready low", 32'(rdy1), 32'd0);
            end
            if (n == 17) chk("bp run", 32'(run1), 32'd1);
        end
        s_axis_tvalid = 1'b0;
        enable_f = 1'b0;
        cycle();

`ifdef DAC_STREAM_OFFSET_EN
        // ---- offset saturation ----
        enable = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = 1'b1;
            if (i == 0)      s_axis_tdata = pack(8000, -8000);
            else if (i == 1) s_axis_tdata = pack(100, 0);
            else             s_axis_tdata = pack(0, 0);
            cycle();
        end
        s_axis_tvalid = 1'b0;
        cycle();
        offset_a = 14'd500;
        neg = -500; offset_b = neg[13:0];
        cycle();
        chk("sat pos", 32'(a0), 32'h1FFF);
        chk("sat neg", 32'(b0), 32'h2000);
        neg = -50; offset_a = neg[13:0];
        offset_b = '0;
        cycle();
        chk("off small", 32'(a0), 32'd50);
        offset_a = '0;
        enable = 1'b0;
        cycle();
`endif

        // ---- randomized traffic against the model ----
        enable = 1'b1;
        prob = 60;
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) begin
                case ($urandom_range(2))
                    0:       prob = 20;
                    1:       prob = 70;
                    default: prob = 100;
                endcase
            end
            if (n == 300) begin
                // asynchronous reset mid-stream
                dac_rstn = 1'b0;
                #1;
                model_reset();
                compare_all();
                enable = 1'b0;
                s_axis_tvalid = 1'b0;
                #3;
                dac_rstn = 1'b1;
                cycle();
                chk("rst2 tready", 32'(rdy0), 32'd0);
            end
            enable        = ($urandom_range(79) != 0);
            s_axis_tvalid = ($urandom_range(99) < prob);
            s_axis_tdata  = $urandom();
`ifdef DAC_STREAM_OFFSET_EN
            offset_a = 14'($urandom());
            offset_b = 14'($urandom());
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
